// File: rtl/slice_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : slice_add_sequencer
// Description : Multi-cycle add/sub that ripples one SLICE-bit adder across a
//               WIDTH-bit operand, one slice per clock, behind valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module slice_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int c_N     = WIDTH / SLICE;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_result;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;

    logic [SLICE-1:0]   w_a_sl;
    logic [SLICE-1:0]   w_b_sl;
    logic [SLICE-1:0]   w_sum;
    logic               w_cout;
    logic               w_cin_msb;
    logic [WIDTH-1:0]   w_result_next;

    // Select the active slice and merge the new sum into the result image.
    always_comb begin
        w_a_sl        = '0;
        w_b_sl        = '0;
        w_result_next = r_result;
        for (int j = 0; j < c_N; j++) begin
            if (r_idx == c_IDX_W'(j)) begin
                w_a_sl = r_a[j*SLICE +: SLICE];
                w_b_sl = r_b[j*SLICE +: SLICE];
            end
        end
        {w_cout, w_sum} = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
        for (int j = 0; j < c_N; j++) begin
            if (r_idx == c_IDX_W'(j)) begin
                w_result_next[j*SLICE +: SLICE] = w_sum;
            end
        end
        // Carry into the MSB recovered from the MSB's sum bit and its operands.
        w_cin_msb = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_sum[SLICE-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_a        <= operand_a;
                        r_b        <= operand_b ^ {WIDTH{sub}};
                        r_carry    <= sub;
                        r_idx      <= '0;
                        r_result   <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= w_cout;
                    r_idx    <= r_idx + c_IDX_W'(1);
                    if (r_idx == c_LAST) begin
                        r_carry_out <= w_cout;
                        r_overflow  <= w_cin_msb ^ w_cout;
                        r_zero      <= (w_result_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_slice_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_slice_add_sequencer
// Description : Directed, table-driven self-checking bench for slice_add_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slice_add_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs [8];

    slice_add_sequencer #(.WIDTH(32), .SLICE(8)) u_dut (
        .clock     (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wait for in_ready, then present one request for exactly the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        sub       = s;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [34:0] snap;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; operand_a = '0; operand_b = '0; sub = 1'b0; out_ready = 1'b1;

        // Reset: hold three cycles, in_ready low throughout.
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_during_reset", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_flags", {61'd0, carry_out, overflow, zero}, 64'd0);

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("v%0d_result", i), {32'd0, result}, {32'd0, vecs[i].r});
            chk($sformatf("v%0d_cvz", i), {61'd0, carry_out, overflow, zero},
                {61'd0, vecs[i].c, vecs[i].v, vecs[i].z});
            @(posedge clk); #1;
            chk($sformatf("v%0d_retire", i), {62'd0, out_valid, in_ready}, 64'd1);
        end

        // Backpressure with spurious requests during RUN and DONE.
        out_ready = 1'b0;
        start_op(32'd5, 32'd7, 1'b1);
        in_valid = 1'b1; operand_a = 32'd99; operand_b = 32'd1; sub = 1'b0;
        wait_done(lat);
        chk("bp_latency", 64'(lat), 64'd4);
        chk("bp_result", {32'd0, result}, 64'hFFFF_FFFE);
        chk("bp_cvz", {61'd0, carry_out, overflow, zero}, 64'd0);
        snap = {result, carry_out, overflow, zero};
        for (int c = 0; c < 10; c++) begin
            in_valid  = c[0];
            operand_a = 32'(c + 100);
            @(posedge clk); #1;
            chk("bp_stable", {29'd0, snap}, {29'd0, result, carry_out, overflow, zero});
            chk("bp_handshake", {62'd0, out_valid, in_ready}, 64'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_retire", {62'd0, out_valid, in_ready}, 64'd1);
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); #1;
                seen = seen | out_valid;
            end
            chk("bp_no_extra_op", {63'd0, seen}, 64'd0);
        end

        // Reset on the second RUN cycle aborts the operation.
        start_op(32'd10, 32'd20, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic seen = 1'b0;
            @(posedge clk); #1;
            chk("abort_idle_ready", {63'd0, in_ready}, 64'd1);
            for (int c = 0; c < 8; c++) begin
                seen = seen | out_valid;
                @(posedge clk); #1;
            end
            chk("abort_no_valid", {63'd0, seen}, 64'd0);
        end
        start_op(32'd3, 32'd4, 1'b0);
        wait_done(lat);
        chk("post_abort_latency", 64'(lat), 64'd4);
        chk("post_abort_result", {32'd0, result}, 64'd7);
        chk("post_abort_cvz", {61'd0, carry_out, overflow, zero}, 64'd0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slice_add_sequencer.md
# slice_add_sequencer

Multi-cycle adder/subtractor controller that sequences a single 8-bit add slice across a wide operand, one byte per clock, with the carry held in a register between slices. Sits in the ALU beside the parallel adder as the area-reduced add/sub path. Requests arrive and results leave through valid/ready handshakes. It produces sum, carry-out, signed overflow and zero flags.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of SLICE
- SLICE, 8, bits added per cycle; slice count N = WIDTH/SLICE (4 at defaults)
- clock  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- operand_a  input  WIDTH  first operand
- operand_b  input  WIDTH  second operand
- sub  input  1  1 = A − B, 0 = A + B
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  sum or difference, mod 2^WIDTH
- carry_out  output  1  carry out of the MSB; for subtract, 1 = no borrow
- overflow  output  1  two's-complement signed overflow
- zero  output  1  result == 0

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready = 1.
  - A clock edge with in_valid & in_ready latches operand_a, {WIDTH{sub}} ^ operand_b and sub.
  - At that edge: carry register = sub, slice index = 0, result register cleared, state → RUN.
- RUN:
  - in_ready = 0. Each cycle computes {c, s} = A[i] + B'[i] + carry, where [i] is the slice at index i.
  - Writes s into result slice i, sets carry = c, and increments i.
  - On the edge that processes slice N−1:
    - carry_out = c
    - overflow = carry into MSB XOR carry out of MSB
    - zero = (final result == 0)
    - state → DONE
- DONE:
  - out_valid = 1. result and flags stay stable until out_valid & out_ready is seen on an edge.
  - On that edge: state → IDLE, out_valid → 0.
  - in_ready stays 0 in DONE. There is no same-edge accept-and-retire.
- Input operands are don't-care outside the accept edge. Changes to them during RUN or DONE have no effect.
- Arithmetic is unsigned modular; overflow is the only signed interpretation.

## Timing
- Reset values: in_ready = 0 while reset is asserted and 1 on the first cycle after release; out_valid = 0; result = 0; carry_out = 0; overflow = 0; zero = 0; state = IDLE.
- Reset has priority over every other event.
- Reset asserted in RUN or DONE aborts the operation. No out_valid is produced for it, and the partial result is discarded.
- Latency: accept on edge k, out_valid high after edge k+N (k+4 at defaults). Slice i is written on edge k+1+i.
- Throughput: one operation per N+2 cycles when out_ready is held high (accept, N RUN cycles, retire).
- Backpressure: out_ready low holds DONE indefinitely; all outputs stay bit-stable.
- in_valid asserted while in_ready = 0 is ignored. The requester must hold the request until accepted.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset release:
  - Stimulus: hold reset for 3 cycles, then release with in_valid = 0.
  - Required: in_ready = 1, out_valid = 0, result = 0, flags = 0.
- Add with full carry ripple:
  - Stimulus: A = 0xFFFFFFFF, B = 0x00000001, sub = 0.
  - Required: out_valid exactly 4 cycles after the accept edge; result = 0x00000000, carry_out = 1, overflow = 0, zero = 1.
- Signed overflow, subtract:
  - Stimulus: A = 0x80000000, B = 0x00000001, sub = 1.
  - Required: result = 0x7FFFFFFF, carry_out = 1, overflow = 1, zero = 0.
- Add overflow:
  - Stimulus: A = 0x7FFFFFFF, B = 0x00000001, sub = 0.
  - Required: result = 0x80000000, carry_out = 0, overflow = 1.
- Backpressure and ignored request:
  - Stimulus: A = 5, B = 7, sub = 1. Hold out_ready = 0 for 10 cycles, and pulse in_valid with different operands during RUN and DONE.
  - Required: result = 0xFFFFFFFE, carry_out = 0 (borrow), overflow = 0, stable throughout the stall. The extra request is not accepted; in_ready returns to 1 one cycle after the retire edge.
- Reset mid-operation:
  - Stimulus: assert reset on the second RUN cycle.
  - Required: the next cycle shows IDLE values, out_valid never rises for the aborted request, and a following request (3 + 4) returns 7.
